// File: rtl/next_pc_redirect_unit.sv
// IF/ID register plus control-transfer redirect and operand-wait hold.
// BRANCH_DELAY_SLOT_EN: keep the delay-slot instruction and link to PC+8.
module next_pc_redirect_unit #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instruction,
  input  logic [31:0] PCNow,
  input  logic [31:0] PCNext4,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic        OperandValid,
  output logic [31:0] NewPC,
  output logic        Jump,
  output logic [31:0] IDInstruction,
  output logic [31:0] IDPCNext4,
  output logic        IDValid,
  output logic        LinkWrite,
  output logic [31:0] LinkAddr,
  output logic        WaitTimeout
);

  typedef enum logic {RUN, WAIT_OPND} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_q, to_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       pc4_q, pc4_d;
  logic              v_q, v_d;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        is_j, is_jal, is_jr, is_beq, is_bne;
  logic        eq, hold, taken;
  logic [31:0] boff, tgt;

  assign op     = ir_q[31:26];
  assign fn     = ir_q[5:0];
  assign is_j   = v_q && (op == 6'h02);
  assign is_jal = v_q && (op == 6'h03);
  assign is_jr  = v_q && (op == 6'h00) && (fn == 6'h08);
  assign is_beq = v_q && (op == 6'h04);
  assign is_bne = v_q && (op == 6'h05);
  assign eq     = (RsData == RtData);
  assign boff   = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  assign hold  = (is_jr | is_beq | is_bne) & ~OperandValid;
  assign taken = is_j | is_jal
               | (OperandValid & (is_jr
               | (is_beq & eq) | (is_bne & ~eq)));

  always_comb begin
    tgt = '0;
    unique case (1'b1)
      is_j, is_jal:   tgt = {pc4_q[31:28], ir_q[25:0], 2'b00};
      is_jr:          tgt = RsData;
      is_beq, is_bne: tgt = pc4_q + boff;
      default:        tgt = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    ir_d    = ir_q;
    pc4_d   = pc4_q;
    v_d     = v_q;
    Jump    = 1'b0;
    NewPC   = '0;
    if (Reset) begin
      Jump  = 1'b0;
      NewPC = '0;
    end else if (hold) begin
      Jump    = 1'b1;
      NewPC   = PCNow;
      state_d = WAIT_OPND;
      if (state_q == RUN)
        cnt_d = CNT_ONE;
      else if (cnt_q != CNT_MAX)
        cnt_d = cnt_q + CNT_ONE;
      if (cnt_d >= CNT_LIM)
        to_d = 1'b1;
    end else begin
      state_d = RUN;
      cnt_d   = '0;
      pc4_d   = PCNext4;
      ir_d    = Instruction;
      v_d     = 1'b1;
      if (taken) begin
        Jump  = 1'b1;
        NewPC = tgt;
`ifndef BRANCH_DELAY_SLOT_EN
        ir_d  = '0;
        v_d   = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      to_q    <= 1'b0;
      ir_q    <= '0;
      pc4_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      ir_q    <= ir_d;
      pc4_q   <= pc4_d;
      v_q     <= v_d;
    end
  end

  assign IDInstruction = ir_q;
  assign IDPCNext4     = pc4_q;
  assign IDValid       = v_q;
  assign WaitTimeout   = to_q;
  assign LinkWrite     = is_jal & ~Reset;
`ifdef BRANCH_DELAY_SLOT_EN
  assign LinkAddr = pc4_q + 32'd4;
`else
  assign LinkAddr = pc4_q;
`endif

endmodule

// File: doc/next_pc_redirect_unit.md
Name: next_pc_redirect_unit

Overview:
- Consumer end of the fetch interface. Registers the fetched Instruction/PCNow/PCNext4 into an IF/ID stage and decodes control transfers (J, JAL, JR, BEQ, BNE).
- Drives NewPC/Jump back to the fetch unit, both to redirect fetch and to hold it while branch operands are not ready.
- Sits between the fetch unit and decode/register-file logic; supplies the ID-stage instruction stream and the JAL link write.

Parameters:
- MAX_WAIT, 15: number of consecutive operand-wait cycles after which WaitTimeout is set (sticky).
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset; same signal as the fetch unit's Reset.
- Instruction  input  32  instruction at PCNow, from fetch.
- PCNow  input  32  current fetch PC.
- PCNext4  input  32  PCNow+4, from fetch.
- RsData  input  32  rs operand value for the ID instruction.
- RtData  input  32  rt operand value for the ID instruction.
- OperandValid  input  1  RsData/RtData are current for the ID instruction.
- NewPC  output  32  redirect/hold target, to fetch.
- Jump  output  1  selects NewPC at fetch.
- IDInstruction  output  32  registered instruction.
- IDPCNext4  output  32  registered PCNext4.
- IDValid  output  1  ID slot holds a real instruction (0 = bubble).
- LinkWrite  output  1  one-cycle pulse: write LinkAddr to $31.
- LinkAddr  output  32  JAL return address.
- WaitTimeout  output  1  sticky: operand wait exceeded MAX_WAIT.

Behaviour:
- Reset (sync, high) clears everything at the clock edge:
  - IDInstruction=0, IDPCNext4=0, IDValid=0, wait counter=0, WaitTimeout=0, state=RUN.
  - While Reset=1: Jump=0, NewPC=0, LinkWrite=0.
  - A reset mid-wait abandons the pending instruction.
- Decode applies to IDInstruction, and only when IDValid=1:
  - J: op=6'h02.
  - JAL: op=6'h03.
  - JR: op=0, funct=6'h08.
  - BEQ: op=6'h04.
  - BNE: op=6'h05.
- Targets:
  - J/JAL: {IDPCNext4[31:28], IDInstruction[25:0], 2'b00}.
  - BEQ/BNE: IDPCNext4 + (sign-extended imm16 << 2), mod 2^32; wrap-around is ignored.
  - JR: RsData.
- Branch conditions: BEQ taken iff RsData==RtData; BNE taken iff RsData!=RtData.
- Jump, NewPC and LinkWrite are combinational from the ID registers, state and operand inputs. Redirect latency: the target is fetched the cycle after the transfer is in ID.
- State RUN:
  - ID holds JR/BEQ/BNE and OperandValid=0: hold. Jump=1, NewPC=PCNow, IF/ID not loaded, counter=1, go to WAIT_OPND.
  - Taken transfer (J, JAL, JR, or taken branch with OperandValid=1): Jump=1, NewPC=target. On that edge the IF/ID load follows the delay-slot rule under Optional Feature.
  - Otherwise: Jump=0. IF/ID loads Instruction/PCNext4 with IDValid=1.
- State WAIT_OPND:
  - OperandValid=0: hold (Jump=1, NewPC=PCNow, IF/ID frozen). Counter saturates at 2^CNT_W-1. When counter reaches MAX_WAIT, WaitTimeout=1 (sticky until Reset).
  - OperandValid=1: resolve in the same cycle exactly as RUN, return to RUN, clear counter.
- Priority: Reset > operand hold > taken redirect > sequential.
- JAL: LinkWrite=1 for exactly the one cycle JAL is resolved in ID, never while holding. LinkAddr=IDPCNext4 (see Optional Feature).
- The first cycle after reset presents IDValid=0 (bubble), so no redirect occurs.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined:
  - On a taken redirect, IF/ID loads the fetched instruction with IDValid=1; the delay slot executes.
  - LinkAddr=IDPCNext4+4.
- Undefined:
  - On a taken redirect, IF/ID loads IDValid=0 and IDInstruction=0; the wrong-path instruction is squashed.
  - LinkAddr=IDPCNext4.

Test Plan:
- Reset, then a sequential stream from PC 0 → IDValid=0 in cycle 1; thereafter IDPCNext4 = 4, 8, 12…; Jump=0 throughout.
- J 0x0000040 (target 0x100) in ID at IDPCNext4=0x14 → Jump=1, NewPC=0x100 for one cycle. Next ID: IDValid=0 without the macro; instruction from 0x14 with IDValid=1 with the macro.
- BEQ imm=-2, RsData=RtData=5, OperandValid=1, IDPCNext4=0x20 → NewPC=0x18, Jump=1. Same with RtData=6 → Jump=0, sequential.
- JR with OperandValid low for 3 cycles, RsData=0x400 → 3 cycles of Jump=1/NewPC=PCNow and ID frozen; 4th cycle NewPC=0x400; WaitTimeout stays 0.
- JAL at IDPCNext4=0x30 → LinkWrite pulse of exactly 1 cycle; LinkAddr=0x30 (0x34 with the macro); Jump=1.
- BNE with OperandValid held low for 16 cycles, then Reset asserted mid-wait → WaitTimeout=1 after cycle 15; Reset clears it and all outputs to 0, state RUN.
